// File: rtl/cle_pkg.sv
// Shared types and constants for the connected-component label-map path.
package cle_pkg;

    localparam int IMG_W   = 32;
    localparam int ADDR_W  = 10;
    localparam int LABEL_W = 7;
    localparam int COUNT_W = 11;
    localparam int COORD_W = 5;
    localparam int PIX_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } stat_state_e;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        coord_t             rmin;
        coord_t             rmax;
        coord_t             cmin;
        coord_t             cmax;
    } label_rec_t;

    // An empty entry: zero pixels, bbox inverted so the first pixel sets all four edges.
    localparam label_rec_t REC_EMPTY = '{
        count: '0,
        rmin:  coord_t'(IMG_W - 1),
        rmax:  '0,
        cmin:  coord_t'(IMG_W - 1),
        cmax:  '0
    };

    // Fold one pixel at (row, col) into a label record.
    function automatic label_rec_t rec_accumulate(input label_rec_t rec,
                                                  input coord_t     row,
                                                  input coord_t     col);
        label_rec_t r;
        r       = rec;
        r.count = rec.count + COUNT_W'(1);
        if (row < rec.rmin) r.rmin = row;
        if (row > rec.rmax) r.rmax = row;
        if (col < rec.cmin) r.cmin = col;
        if (col > rec.cmax) r.cmax = col;
        return r;
    endfunction

endpackage

// File: rtl/cle_label_stat_if.sv
// Per-label record stream: valid/ready handshake plus record payload.
interface cle_label_stat_if;
    import cle_pkg::*;

    logic               out_valid;
    logic               out_ready;
    logic [LABEL_W-1:0] out_label;
    logic [COUNT_W-1:0] out_count;
    coord_t             out_rmin;
    coord_t             out_rmax;
    coord_t             out_cmin;
    coord_t             out_cmax;

    modport master (
        output out_valid, out_label, out_count, out_rmin, out_rmax, out_cmin, out_cmax,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_label, out_count, out_rmin, out_rmax, out_cmin, out_cmax,
        output out_ready
    );

endinterface

// File: rtl/cle_label_bank.sv
// Record register file for labels 1..MAX_LABEL: one accumulate port with
// same-cycle read-modify-write, one combinational read port that sees a
// pending accumulate to the same label, and a synchronous clear-all.
module cle_label_bank
    import cle_pkg::*;
#(
    parameter int MAX_LABEL = 32
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               acc_en,
    input  logic [LABEL_W-1:0] acc_label,
    input  coord_t             acc_row,
    input  coord_t             acc_col,
    input  logic [LABEL_W-1:0] rd_label,
    output label_rec_t         rd_rec
);

    label_rec_t entry_q [1:MAX_LABEL];
    label_rec_t entry_d [1:MAX_LABEL];
    label_rec_t acc_cur;
    label_rec_t acc_rec;

    // Updated record for the label being accumulated this cycle.
    always_comb begin
        acc_cur = REC_EMPTY;
        for (int i = 1; i <= MAX_LABEL; i++) begin
            if (acc_label == LABEL_W'(i)) acc_cur = entry_q[i];
        end
        acc_rec = rec_accumulate(acc_cur, acc_row, acc_col);
    end

    // Next contents: clear-all wins, otherwise write back the accumulated entry.
    always_comb begin
        for (int i = 1; i <= MAX_LABEL; i++) begin
            if (clear) begin
                entry_d[i] = REC_EMPTY;
            end else if (acc_en && (acc_label == LABEL_W'(i))) begin
                entry_d[i] = acc_rec;
            end else begin
                entry_d[i] = entry_q[i];
            end
        end
    end

    // Read port; out-of-range labels read as an empty (count 0) record.
    always_comb begin
        rd_rec = '0;
        for (int i = 1; i <= MAX_LABEL; i++) begin
            if (rd_label == LABEL_W'(i)) begin
                rd_rec = (acc_en && (acc_label == rd_label)) ? acc_rec : entry_q[i];
            end
        end
    end

    // Storage update.
    // NOTE: the array has no reset; every sweep starts with a CLEAR cycle, so its
    // power-up contents are never observed and a reset tree here buys nothing.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: rtl/cle_label_stat.sv
// Label-map reader: sweeps the 32x32 label SRAM, accumulates per-label pixel
// count and bounding box, then streams one record per present label.
module cle_label_stat
    import cle_pkg::*;
#(
    parameter int MAX_LABEL = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] sram_a,
    input  logic [PIX_W-1:0]  sram_q,
    output logic              busy,
    output logic              overflow,
    output logic              done,
    cle_label_stat_if.master  rec_if
);

    localparam logic [PIX_W-1:0]   MAX_PIX   = PIX_W'(MAX_LABEL);
    localparam logic [LABEL_W-1:0] LAST_IDX  = LABEL_W'(MAX_LABEL);
    localparam logic [ADDR_W:0]    SCAN_LAST = (ADDR_W + 1)'(IMG_W * IMG_W);

    stat_state_e        state_q, state_d;
    logic [ADDR_W:0]    addr_q, addr_d;          // extra bit counts the drain cycle
    logic               tag_valid_q, tag_valid_d;
    logic [ADDR_W-1:0]  tag_addr_q, tag_addr_d;
    logic [LABEL_W-1:0] idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic [LABEL_W-1:0] out_label_q, out_label_d;
    label_rec_t         out_rec_q, out_rec_d;

    logic               bank_clear;
    logic               acc_en;
    logic               load_rec;
    logic [LABEL_W-1:0] rd_label;
    label_rec_t         rd_rec;

    // Classify the byte returning for the tagged address; the lookahead read
    // targets the next record to present (label 1 while finishing the scan).
    assign acc_en     = tag_valid_q && (sram_q != '0) && (sram_q <= MAX_PIX);
    assign bank_clear = (state_q == ST_CLEAR);
    assign rd_label   = (state_q == ST_SCAN) ? LABEL_W'(1) : idx_q + LABEL_W'(1);

    cle_label_bank #(.MAX_LABEL(MAX_LABEL)) u_bank (
        .clk       (clk),
        .clear     (bank_clear),
        .acc_en    (acc_en),
        .acc_label (sram_q[LABEL_W-1:0]),
        .acc_row   (tag_addr_q[ADDR_W-1 -: COORD_W]),
        .acc_col   (tag_addr_q[COORD_W-1:0]),
        .rd_label  (rd_label),
        .rd_rec    (rd_rec)
    );

    // Next-state and output-register logic for the sweep sequencer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_d     = state_q;
        addr_d      = addr_q;
        tag_valid_d = 1'b0;
        tag_addr_d  = addr_q[ADDR_W-1:0];
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        out_label_d = out_label_q;
        out_rec_d   = out_rec_q;
        load_rec    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                end
            end
            ST_CLEAR: begin
                addr_d     = '0;
                overflow_d = 1'b0;
                state_d    = ST_SCAN;
            end
            ST_SCAN: begin
                tag_valid_d = ~addr_q[ADDR_W];
                if (tag_valid_q && (sram_q > MAX_PIX)) overflow_d = 1'b1;
                if (addr_q == SCAN_LAST) begin
                    state_d  = ST_EMIT;
                    addr_d   = '0;
                    idx_d    = LABEL_W'(1);
                    load_rec = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_EMIT: begin
                if (!out_valid_q || rec_if.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d    = idx_q + LABEL_W'(1);
                        load_rec = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_rec) begin
            out_label_d = rd_label;
            out_rec_d   = rd_rec;
            out_valid_d = (rd_rec.count != '0);
        end
    end

    // State, counters, pipeline tag and output holding registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            tag_valid_q <= 1'b0;
            tag_addr_q  <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_label_q <= '0;
            out_rec_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            state_q     <= state_d;
            addr_q      <= addr_d;
            tag_valid_q <= tag_valid_d;
            tag_addr_q  <= tag_addr_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            out_label_q <= out_label_d;
            out_rec_q   <= out_rec_d;
        end
    end

    assign sram_a           = addr_q[ADDR_W-1:0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign overflow         = overflow_q;
    assign rec_if.out_valid = out_valid_q;
    assign rec_if.out_label = out_label_q;
    assign rec_if.out_count = out_rec_q.count;
    assign rec_if.out_rmin  = out_rec_q.rmin;
    assign rec_if.out_rmax  = out_rec_q.rmax;
    assign rec_if.out_cmin  = out_rec_q.cmin;
    assign rec_if.out_cmax  = out_rec_q.cmax;

endmodule

// File: doc/cle_label_stat.md
# cle_label_stat

Label-map reader for the connected-component path. It sweeps the 32x32 label SRAM (one byte per pixel, 0 = background, 1..127 = component label) after labeling finishes. It accumulates per-label pixel count and bounding box, then streams one record per present label over a valid/ready port. It reads through the same SRAM port the labeler writes, so it acts as the consumer end of the label-map interface.

## Interface
- MAX_LABEL, 32: highest label tracked (1..MAX_LABEL); larger labels set `overflow` and are otherwise ignored.
- clk  in  1  single clock, all flops on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- sram_a  out  10  read address, row*32+col (row = addr[9:5], col = addr[4:0]).
- sram_q  in  8  read data, valid exactly one cycle after `sram_a` is presented.
- busy  out  1  high from the cycle after accepted `start` until `done`.
- out_valid  out  1  record available.
- out_ready  in  1  consumer accepts the record when high with `out_valid`.
- out_label  out  7  label id.
- out_count  out  11  pixel count, 1..1024.
- out_rmin, out_rmax, out_cmin, out_cmax  out  5 each  bounding box (row/col, inclusive).
- overflow  out  1  sticky per sweep; a label > MAX_LABEL was seen.
- done  out  1  one-cycle pulse after the last record is accepted.

## Operation
- States: IDLE -> CLEAR -> SCAN -> EMIT -> DONE -> IDLE.
- IDLE: `start`=1 -> CLEAR. `start` in any other state is ignored.
- CLEAR, 1 cycle: all entries get count=0, rmin=cmin=31, rmax=cmax=0. `overflow` cleared. `sram_a`=0.
- SCAN: `sram_a` steps 0..1023, one address per cycle. A 1-stage pipeline tags each returning `sram_q` with the row/col of its address.
- Per returned byte q, with q=0 skipped:
  - 1<=q<=MAX_LABEL: count[q]+1; rmin/rmax/cmin/cmax updated with min/max of the tagged row/col.
  - q>MAX_LABEL: `overflow`=1.
- Back-to-back pixels with the same label must accumulate correctly; same-cycle read-modify-write of the register entry, no hazard.
- SCAN ends when data for address 1023 has been processed, which is 1025 cycles after entering SCAN.
- EMIT: index L runs 1..MAX_LABEL.
  - count[L]=0: skip, 1 cycle.
  - Otherwise: present the record with `out_valid`=1 and hold all out_* stable until `out_ready`=1, then advance.
  - `out_valid` never drops without a handshake.
- After L=MAX_LABEL is finished -> DONE: `done`=1 for one cycle, `busy`=0 -> IDLE.
- `overflow` stays valid until the next CLEAR.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. Partial statistics are discarded. The next `start` works normally.

## Timing
- Reset values: sram_a=0, busy=0, out_valid=0, out_label=0, out_count=0, bbox outputs=0, overflow=0, done=0.
- `start` sampled at edge t: CLEAR during t+1, first address at t+2.
- `out_valid` cannot rise earlier than 1025 cycles after SCAN entry.
- With `out_ready` tied high: EMIT takes exactly MAX_LABEL cycles regardless of how many labels are present (one cycle per index), then 1 DONE cycle.
- No combinational path from `out_ready` to `out_valid` or out_* data.

## Structure
- Shared package `cle_pkg`:
  - IMG_W=32, ADDR_W=10, LABEL_W=7, COUNT_W=11.
  - State enum for this block.
  - Packed struct for a label record: count, rmin, rmax, cmin, cmax.
- Sub-module `cle_label_bank`: MAX_LABEL-entry record register file.
  - One combinational read port (EMIT).
  - One accumulate port: label, row, col, enable.
  - Synchronous clear-all.
- Top-level FSM, address counter, read-data pipeline tag and output holding registers live in `cle_label_stat`.

## Test plan
- All-zero SRAM, out_ready=1 → no `out_valid`; `done` pulses exactly 1+1025+32+1 cycles after `start` is sampled; overflow=0.
- Single byte 3 at address 37 → one record: label=3, count=1, rmin=rmax=1, cmin=cmax=5.
- All 1024 bytes = 1 → one record: label=1, count=1024, rmin=0, rmax=31, cmin=0, cmax=31.
- Labels 2 and 5 each as 2x2 blocks at rows 0-1/cols 0-1 and rows 30-31/cols 30-31, plus one byte of 40 → records label 2 then label 5, each with count=4 and the correct bbox; overflow=1; no record for 40.
- out_ready low for 5 cycles while a record is valid → all out_* stable across those cycles; one handshake when out_ready rises; no duplicate record.
- reset low mid-SCAN (address 500) → all outputs at reset values. A `start` pulse while busy is ignored. A fresh `start` after reset gives results identical to an uninterrupted sweep.
